// File: rtl/store_align_buffer_pkg.sv
// Shared types for the store alignment buffer: access-size encodings,
// the queued write entry and the alignment rule for store requests.
package store_pkg;

  // Widest byte address an entry can carry; narrower AW values zero-extend.
  localparam int unsigned AW_MAX = 64;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef struct packed {
    logic [AW_MAX-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } entry_t;

  // A request is rejected when it is not naturally aligned or its size is illegal.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    logic bad;
    unique case (size)
      SZ_WORD: bad = (lo != 2'b00);
      SZ_HALF: bad = lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_align_buffer_if.sv
// Store request side and memory write side of the store alignment buffer.
interface store_align_buffer_if #(
  parameter int unsigned AW = 32
);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  // Buffer side: accepts stores, drives the memory write port.
  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );

  // Environment side: issues stores and acts as the data memory.
  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_lane_align.sv
// Combinational lane placement for store data: narrows to byte/halfword,
// replicates across lanes, builds byte enables and flags misalignment.
module store_lane_align
  import store_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [31:0]   data,
  input  logic [1:0]    size,
  output entry_t        ent,
  output logic          misalign
);

  // Lane replication and byte-enable generation per access size.
  always_comb begin
    ent       = '0;
    ent.addr  = AW_MAX'({addr[AW-1:2], 2'b00});
    unique case (size_e'(size))
      SZ_BYTE: begin
        ent.wdata = {4{data[7:0]}};
        ent.be    = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        ent.wdata = {2{data[15:0]}};
        ent.be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        ent.wdata = data;
        ent.be    = 4'b1111;
      end
      default: begin
        ent.wdata = '0;
        ent.be    = '0;
      end
    endcase
    misalign = is_misaligned(size_e'(size), addr[1:0]);
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store alignment buffer: aligns store data onto memory byte lanes and
// queues the writes in a DEPTH-entry FIFO drained over valid/ready.
// Optional feature macro: STORE_BUF_FWD_EN adds ld_addr/ld_hit, a
// combinational word-address match against all buffered entries.
module store_align_buffer
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  store_align_buffer_if.slave    bus,
  output logic                   misalign_err,
  output logic [$clog2(DEPTH):0] count
`ifdef STORE_BUF_FWD_EN
  ,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          fifo [DEPTH];
  entry_t          head_q;
  entry_t          head_nxt;
  entry_t          ent;
  logic            load_head;
  logic            misalign;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            write;
  logic            pop;

  store_lane_align #(.AW(AW)) u_align (
    .addr     (bus.st_addr),
    .data     (bus.st_data),
    .size     (bus.st_size),
    .ent      (ent),
    .misalign (misalign)
  );

  assign push  = bus.st_valid && bus.st_ready;
  assign write = push && !misalign;
  assign pop   = bus.mem_valid && bus.mem_ready;

  assign bus.st_ready  = (count != CW'(DEPTH));
  assign bus.mem_valid = (count != '0);
  assign bus.mem_addr  = head_q.addr[AW-1:0];
  assign bus.mem_wdata = head_q.wdata;
  assign bus.mem_be    = bus.mem_valid ? head_q.be : '0;

  // The head copy is kept in its own register so the memory port holds the
  // last drained entry when empty; this picks what the head becomes next.
  always_comb begin
    head_nxt  = head_q;
    load_head = 1'b0;
    if (count == '0) begin
      if (write) begin
        head_nxt  = ent;
        load_head = 1'b1;
      end
    end else if (pop) begin
      if (count == CW'(1)) begin
        if (write) begin
          head_nxt  = ent;
          load_head = 1'b1;
        end
      end else begin
        head_nxt  = fifo[rd_ptr + PW'(1)];
        load_head = 1'b1;
      end
    end
  end

  // FIFO storage, pointers, occupancy, head register and error pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
      head_q       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (write) begin
        fifo[wr_ptr] <= ent;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (load_head) head_q <= head_nxt;
      misalign_err <= push && misalign;
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Entry i is live when its distance from the read pointer is below count.
  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - rd_ptr)) < count) &&
          (fifo[i].addr == AW_MAX'({ld_addr[AW-1:2], 2'b00})))
        ld_hit = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed self-checking bench for store_align_buffer (DEPTH=4, AW=32).
module tb_store_align_buffer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        misalign_err;
  logic [2:0]  count;
`ifdef STORE_BUF_FWD_EN
  logic [31:0] ld_addr;
  logic        ld_hit;
`endif

  int checks = 0;
  int errors = 0;

  store_align_buffer_if #(.AW(32)) bus ();

  store_align_buffer #(.DEPTH(4), .AW(32)) u_dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .bus          (bus),
    .misalign_err (misalign_err),
    .count        (count)
`ifdef STORE_BUF_FWD_EN
    ,
    .ld_addr      (ld_addr),
    .ld_hit       (ld_hit)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = s;
  endtask

  task automatic test_reset;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %h want 0", bus.mem_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %h want 1", bus.st_ready); end
    checks++; if (bus.mem_be !== 4'b0000) begin errors++; $display("FAIL reset_mem_be got %b want 0000", bus.mem_be); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %h want 0", misalign_err); end
    Rst = 1'b1;
    step;
  endtask

  task automatic test_byte;
    drive(1'b1, 32'h1003, 32'hAABBCCDD, 2'b10);
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL byte_no_bypass got %h want 0", bus.mem_valid); end
    step;
    bus.st_valid = 1'b0;
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL byte_valid got %h want 1", bus.mem_valid); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL byte_count got %0d want 1", count); end
    checks++; if (bus.mem_addr !== 32'h1000) begin errors++; $display("FAIL byte_addr got %h want 00001000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hDDDDDDDD) begin errors++; $display("FAIL byte_wdata got %h want DDDDDDDD", bus.mem_wdata); end
    checks++; if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL byte_be got %b want 1000", bus.mem_be); end
    bus.mem_ready = 1'b1;
    step;
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL byte_drained got %h want 0", bus.mem_valid); end
    checks++; if (bus.mem_be !== 4'b0000) begin errors++; $display("FAIL byte_empty_be got %b want 0000", bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'hDDDDDDDD) begin errors++; $display("FAIL byte_hold_wdata got %h want DDDDDDDD", bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 32'h1000) begin errors++; $display("FAIL byte_hold_addr got %h want 00001000", bus.mem_addr); end
  endtask

  task automatic test_half_word;
    drive(1'b1, 32'h2002, 32'h12345678, 2'b01);
    step;
    drive(1'b1, 32'h2004, 32'hCAFEF00D, 2'b00);
    step;
    bus.st_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL half_count got %0d want 2", count); end
    checks++; if (bus.mem_addr !== 32'h2000) begin errors++; $display("FAIL half_addr got %h want 00002000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h56785678) begin errors++; $display("FAIL half_wdata got %h want 56785678", bus.mem_wdata); end
    checks++; if (bus.mem_be !== 4'b1100) begin errors++; $display("FAIL half_be got %b want 1100", bus.mem_be); end
    bus.mem_ready = 1'b1;
    step;
    checks++; if (bus.mem_addr !== 32'h2004) begin errors++; $display("FAIL word_addr got %h want 00002004", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL word_wdata got %h want CAFEF00D", bus.mem_wdata); end
    checks++; if (bus.mem_be !== 4'b1111) begin errors++; $display("FAIL word_be got %b want 1111", bus.mem_be); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL word_count got %0d want 1", count); end
    step;
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL half_word_drained got %h want 0", bus.mem_valid); end
  endtask

  task automatic test_misalign;
    logic [1:0] szs [3];
    szs = '{2'b00, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3001, 32'h11223344, szs[i]);
      checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL mis_ready[%0d] got %h want 1", i, bus.st_ready); end
      step;
      bus.st_valid = 1'b0;
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_pulse[%0d] got %h want 1", i, misalign_err); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mis_count[%0d] got %0d want 0", i, count); end
      checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL mis_valid[%0d] got %h want 0", i, bus.mem_valid); end
      step;
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_one_cycle[%0d] got %h want 0", i, misalign_err); end
    end
  endtask

  task automatic test_backpressure;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h5000 + 32'(4 * k), 32'hA0000000 + 32'(k), 2'b00);
      checks++; if (bus.st_ready !== (k < 4)) begin errors++; $display("FAIL bp_ready[%0d] got %h want %h", k, bus.st_ready, (k < 4)); end
      step;
      checks++; if (count !== 3'((k < 4) ? k + 1 : 4)) begin errors++; $display("FAIL bp_count[%0d] got %0d", k, count); end
    end
    bus.st_valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      checks++; if (bus.mem_addr !== 32'h5000) begin errors++; $display("FAIL bp_hold_addr[%0d] got %h want 00005000", h, bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 32'hA0000000) begin errors++; $display("FAIL bp_hold_wdata[%0d] got %h want A0000000", h, bus.mem_wdata); end
      checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready[%0d] got %h want 0", h, bus.st_ready); end
      step;
    end
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      checks++; if (count !== 3'(3 - k)) begin errors++; $display("FAIL bp_drain_count[%0d] got %0d want %0d", k, count, 3 - k); end
      if (k == 0) begin
        checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %h want 1", bus.st_ready); end
      end
      if (k < 3) begin
        checks++; if (bus.mem_wdata !== 32'hA0000000 + 32'(k + 1)) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", k, bus.mem_wdata, 32'hA0000000 + 32'(k + 1)); end
        checks++; if (bus.mem_addr !== 32'h5000 + 32'(4 * (k + 1))) begin errors++; $display("FAIL bp_order_addr[%0d] got %h", k, bus.mem_addr); end
      end
    end
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %h want 0", bus.mem_valid); end
  endtask

  task automatic test_back_to_back;
    bus.mem_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 32'h6000 + 32'(4 * n), 32'h100 + 32'(n), 2'b00);
      step;
    end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_fill got %0d want 2", count); end
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h6000 + 32'(4 * (i + 2)), 32'h100 + 32'(i + 2), 2'b00);
      step;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 2", i, count); end
      checks++; if (bus.mem_wdata !== 32'h100 + 32'(i + 1)) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, bus.mem_wdata, 32'h100 + 32'(i + 1)); end
      checks++; if (bus.mem_addr !== 32'h6000 + 32'(4 * (i + 1))) begin errors++; $display("FAIL b2b_addr[%0d] got %h", i, bus.mem_addr); end
    end
    bus.st_valid = 1'b0;
    step;
    checks++; if (bus.mem_wdata !== 32'h10B) begin errors++; $display("FAIL b2b_tail got %h want 0000010B", bus.mem_wdata); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_tail_count got %0d want 1", count); end
    step;
    bus.mem_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d want 0", count); end
  endtask

  task automatic test_async_reset;
    bus.mem_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 32'h7000 + 32'(4 * n), 32'h77 + 32'(n), 2'b00);
      step;
    end
    bus.st_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL ar_pre_count got %0d want 3", count); end
    #2 Rst = 1'b0;
    #1;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %h want 0", bus.mem_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count got %0d want 0", count); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %h want 1", bus.st_ready); end
    #2 Rst = 1'b1;
    drive(1'b1, 32'h7002, 32'h00000055, 2'b10);
    step;
    bus.st_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL ar_post_count got %0d want 1", count); end
    checks++; if (bus.mem_be !== 4'b0100) begin errors++; $display("FAIL ar_post_be got %b want 0100", bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'h55555555) begin errors++; $display("FAIL ar_post_wdata got %h want 55555555", bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 32'h7000) begin errors++; $display("FAIL ar_post_addr got %h want 00007000", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    step;
    bus.mem_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_drain got %0d want 0", count); end
  endtask

`ifdef STORE_BUF_FWD_EN
  task automatic test_fwd;
    drive(1'b1, 32'h4001, 32'h00000099, 2'b10);
    step;
    bus.st_valid = 1'b0;
    ld_addr = 32'h4002;
    #1;
    checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit got %h want 1", ld_hit); end
    ld_addr = 32'h4004;
    #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss got %h want 0", ld_hit); end
    ld_addr = 32'h4002;
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL fwd_pop_hit got %h want 1", ld_hit); end
    step;
    bus.mem_ready = 1'b0;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_drained got %h want 0", ld_hit); end
  endtask
`endif

  initial begin
    Rst = 1'b1;
    bus.mem_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
`ifdef STORE_BUF_FWD_EN
    ld_addr = 32'h0;
`endif
    #2 Rst = 1'b0;
    step;
    test_reset;
    test_byte;
    test_half_word;
    test_misalign;
    test_backpressure;
    test_back_to_back;
    test_async_reset;
`ifdef STORE_BUF_FWD_EN
    test_fwd;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
